// File: rtl/uart_io_pkg.sv
// Shared definitions for the CPU-side UART output port: register map,
// ASCII codes, STATUS layout, FIFO entry format and drain FSM states.
package uart_io_pkg;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_IDLE  = 1;
  localparam int unsigned STAT_COUNT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_LF
  } drain_state_t;

  typedef struct packed {
    logic       expand;
    logic [7:0] ch;
  } fifo_entry_t;

endpackage

// File: rtl/uart_io_port_if.sv
// CPU load/store bus into the UART output port.
interface uart_io_port_if;
  logic [1:0]  io_adr;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_stall;

  modport master (
    output io_adr, io_we, io_re, io_wdata,
    input  io_rdata, io_stall
  );

  modport slave (
    input  io_adr, io_we, io_re, io_wdata,
    output io_rdata, io_stall
  );
endinterface

// File: rtl/uart_io_fifo.sv
// Synchronous FIFO of {expand, char} entries with registered occupancy count.
module uart_io_fifo
  import uart_io_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  fifo_entry_t          wr_data,
  output fifo_entry_t          rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  fifo_entry_t            mem [DEPTH];
  logic [DEPTH_LOG-1:0]   wr_ptr;
  logic [DEPTH_LOG-1:0]   rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  // count never exceeds DEPTH, so its top bit alone marks full
  assign full    = count[DEPTH_LOG];
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array, written on accepted push only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; count tracks push/pop balance
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_io_port.sv
// Memory-mapped UART output port: CPU writes are queued and drained to the
// UART monitor one character per two cycles, with optional LF -> CR+LF.
module uart_io_port
  import uart_io_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 3,
  parameter logic        CRLF_RST  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_io_port_if.slave        bus,
  output logic [7:0]           uart_io_char,
  output logic                 uart_io_we,
  input  logic                 uart_io_full,
  output logic                 tx_idle
);

  drain_state_t         state;
  fifo_entry_t          push_entry;
  fifo_entry_t          head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DEPTH_LOG:0]   count;
  logic                 crlf_en;
  logic                 data_wr;
  logic                 push;
  logic                 pop;
  logic                 unused_wdata;

  assign unused_wdata = ^bus.io_wdata[31:8];

  assign data_wr      = bus.io_we & (bus.io_adr == ADR_DATA);
  assign push         = data_wr & ~fifo_full;
  assign bus.io_stall = data_wr & fifo_full;

  assign push_entry.expand = crlf_en & (bus.io_wdata[7:0] == ASCII_LF);
  assign push_entry.ch     = bus.io_wdata[7:0];

  // An expanded LF stays at the head until its second (LF) strobe goes out
  assign pop = ((state == ST_IDLE) & ~fifo_empty & ~uart_io_full & ~head.expand)
             | ((state == ST_LF) & ~uart_io_we & ~uart_io_full);

  assign tx_idle = (count == '0) & (state == ST_IDLE) & ~uart_io_we;

  uart_io_fifo #(.DEPTH_LOG(DEPTH_LOG)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Control register: CR+LF expansion enable
  always_ff @(posedge clk) begin
    if (rst) begin
      crlf_en <= CRLF_RST;
    end else if (bus.io_we && (bus.io_adr == ADR_CTRL)) begin
      crlf_en <= bus.io_wdata[0];
    end
  end

  // Combinational register read-back
  always_comb begin
    bus.io_rdata = '0;
    if (bus.io_re) begin
      unique case (bus.io_adr)
        ADR_STATUS: begin
          bus.io_rdata[STAT_FULL]                 = fifo_full;
          bus.io_rdata[STAT_IDLE]                 = tx_idle;
          bus.io_rdata[STAT_COUNT +: DEPTH_LOG+1] = count;
        end
        ADR_CTRL: bus.io_rdata[0] = crlf_en;
        default:  bus.io_rdata = '0;
      endcase
    end
  end

  // Drain FSM: a GAP cycle follows every strobe so uart_io_full is sampled
  // only after the monitor has seen the previous character
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      uart_io_char <= '0;
      uart_io_we   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty && !uart_io_full) begin
            uart_io_we <= 1'b1;
            if (head.expand) begin
              uart_io_char <= ASCII_CR;
              state        <= ST_LF;
            end else begin
              uart_io_char <= head.ch;
              state        <= ST_GAP;
            end
          end else begin
            uart_io_we <= 1'b0;
          end
        end
        ST_LF: begin
          // uart_io_we still high means the CR is on the wire this cycle
          if (uart_io_we) begin
            uart_io_we <= 1'b0;
          end else if (!uart_io_full) begin
            uart_io_char <= ASCII_LF;
            uart_io_we   <= 1'b1;
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          uart_io_we <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          uart_io_we <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_port.sv
// Directed bench for uart_io_port: register access, FIFO back-pressure,
// CR+LF expansion, reset in the LF state and push/pop interaction.
module tb_uart_io_port;
  import uart_io_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] uart_io_char;
  logic       uart_io_we;
  logic       uart_io_full;
  logic       tx_idle;

  uart_io_port_if bus ();

  uart_io_port #(.DEPTH_LOG(3), .CRLF_RST(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .uart_io_char (uart_io_char),
    .uart_io_we   (uart_io_we),
    .uart_io_full (uart_io_full),
    .tx_idle      (tx_idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] seen[$];
  int         cyc = 0;
  int         last_strobe = -10;
  int         gap_viol = 0;

  // Record every strobe and flag strobes on adjacent cycles
  always @(negedge clk) begin
    cyc++;
    if (uart_io_we === 1'b1) begin
      if (cyc - last_strobe < 2) gap_viol++;
      last_strobe = cyc;
      seen.push_back(uart_io_char);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [1:0] adr, output logic [31:0] data);
    bus.io_adr = adr;
    bus.io_re  = 1'b1;
    #1;
    data = bus.io_rdata;
    bus.io_re = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] adr, input logic [7:0] data);
    bus.io_adr   = adr;
    bus.io_wdata = {24'h0, data};
    bus.io_we    = 1'b1;
    step();
    bus.io_we    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (tx_idle !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check(tag, 32'(tx_idle), 32'h1);
  endtask

  task automatic check_seq(input string tag, input int base, input logic [7:0] exp[$]);
    check({tag, "_len"}, 32'(seen.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < seen.size())
        check(tag, 32'(seen[base + i]), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  exp[$];
    int          base;

    rst          = 1'b1;
    bus.io_we    = 1'b0;
    bus.io_re    = 1'b0;
    bus.io_adr   = 2'd0;
    bus.io_wdata = 32'h0;
    uart_io_full = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_we", 32'(uart_io_we), 32'h0);
    check("rst_char", 32'(uart_io_char), 32'h0);
    check("rst_idle", 32'(tx_idle), 32'h1);
    check("rst_stall", 32'(bus.io_stall), 32'h0);
    check("rst_rdata_nore", bus.io_rdata, 32'h0);
    read_reg(ADR_STATUS, rd);
    check("rst_status", rd, 32'h0000_0002);
    read_reg(ADR_CTRL, rd);
    check("rst_ctrl", rd, 32'h0);
    read_reg(2'd3, rd);
    check("reserved_read", rd, 32'h0);

    // Single char: strobe two edges after acceptance
    base = seen.size();
    bus.io_adr   = ADR_DATA;
    bus.io_wdata = 32'h41;
    bus.io_we    = 1'b1;
    #1;
    check("single_stall", 32'(bus.io_stall), 32'h0);
    step();
    bus.io_we = 1'b0;
    check("single_we_n1", 32'(uart_io_we), 32'h0);
    check("single_idle_n1", 32'(tx_idle), 32'h0);
    step();
    check("single_we_n2", 32'(uart_io_we), 32'h1);
    check("single_char_n2", 32'(uart_io_char), 32'h41);
    step();
    check("single_we_gap", 32'(uart_io_we), 32'h0);
    check("single_char_hold", 32'(uart_io_char), 32'h41);
    step();
    check("single_idle_back", 32'(tx_idle), 32'h1);
    exp = '{8'h41};
    check_seq("single_seq", base, exp);

    // Burst of 9 with monitor full: 9th stalls
    base = seen.size();
    uart_io_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.io_adr   = ADR_DATA;
      bus.io_wdata = 32'h30 + 32'(i);
      bus.io_we    = 1'b1;
      #1;
      check("burst_stall", 32'(bus.io_stall), (i == 8) ? 32'h1 : 32'h0);
      if (i < 8) step();
    end
    step();
    check("burst_stall_hold", 32'(bus.io_stall), 32'h1);
    bus.io_we = 1'b0;
    read_reg(ADR_STATUS, rd);
    check("burst_status_full", rd, 32'h0000_0801);
    // Pop at count 8 does not unblock the same-cycle push
    uart_io_full = 1'b0;
    bus.io_adr   = ADR_DATA;
    bus.io_wdata = 32'h38;
    bus.io_we    = 1'b1;
    #1;
    check("poppush8_stall", 32'(bus.io_stall), 32'h1);
    step();
    bus.io_we = 1'b0;
    read_reg(ADR_STATUS, rd);
    check("poppush8_status", rd, 32'h0000_0700);
    bus.io_adr   = ADR_DATA;
    bus.io_wdata = 32'h38;
    bus.io_we    = 1'b1;
    #1;
    check("retry_stall", 32'(bus.io_stall), 32'h0);
    step();
    bus.io_we = 1'b0;
    wait_idle("burst_drain");
    exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    check_seq("burst_seq", base, exp);

    // CRLF with monitor full raised while in LF
    base = seen.size();
    bus.io_adr   = ADR_CTRL;
    bus.io_wdata = 32'h1;
    bus.io_we    = 1'b1;
    #1;
    check("ctrl_stall", 32'(bus.io_stall), 32'h0);
    step();
    bus.io_we = 1'b0;
    read_reg(ADR_CTRL, rd);
    check("ctrl_read1", rd, 32'h1);
    write_reg(ADR_DATA, 8'h0A);
    step();
    check("crlf_cr_we", 32'(uart_io_we), 32'h1);
    check("crlf_cr_char", 32'(uart_io_char), 32'h0D);
    uart_io_full = 1'b1;
    step();
    check("crlf_wait_we", 32'(uart_io_we), 32'h0);
    step();
    check("crlf_hold_we", 32'(uart_io_we), 32'h0);
    check("crlf_hold_idle", 32'(tx_idle), 32'h0);
    read_reg(ADR_STATUS, rd);
    check("crlf_hold_status", rd, 32'h0000_0100);
    step();
    step();
    check("crlf_hold_we2", 32'(uart_io_we), 32'h0);
    uart_io_full = 1'b0;
    step();
    check("crlf_lf_we", 32'(uart_io_we), 32'h1);
    check("crlf_lf_char", 32'(uart_io_char), 32'h0A);
    wait_idle("crlf_drain");
    exp = '{8'h0D, 8'h0A};
    check_seq("crlf_seq", base, exp);

    // Expansion disabled: plain LF
    write_reg(ADR_CTRL, 8'h00);
    read_reg(ADR_CTRL, rd);
    check("ctrl_read0", rd, 32'h0);
    base = seen.size();
    write_reg(ADR_DATA, 8'h0A);
    wait_idle("lf_drain");
    exp = '{8'h0A};
    check_seq("lf_seq", base, exp);

    // Expand bit is fixed at push time
    base = seen.size();
    uart_io_full = 1'b1;
    write_reg(ADR_CTRL, 8'h01);
    write_reg(ADR_DATA, 8'h0A);
    write_reg(ADR_CTRL, 8'h00);
    uart_io_full = 1'b0;
    wait_idle("sticky_drain");
    exp = '{8'h0D, 8'h0A};
    check_seq("sticky_seq", base, exp);

    // Push and pop together at count 3
    base = seen.size();
    uart_io_full = 1'b1;
    write_reg(ADR_DATA, 8'h61);
    write_reg(ADR_DATA, 8'h62);
    write_reg(ADR_DATA, 8'h63);
    read_reg(ADR_STATUS, rd);
    check("pp3_before", rd, 32'h0000_0300);
    uart_io_full = 1'b0;
    bus.io_adr   = ADR_DATA;
    bus.io_wdata = 32'h64;
    bus.io_we    = 1'b1;
    #1;
    check("pp3_stall", 32'(bus.io_stall), 32'h0);
    step();
    bus.io_we = 1'b0;
    read_reg(ADR_STATUS, rd);
    check("pp3_after", rd, 32'h0000_0300);
    wait_idle("pp3_drain");
    exp = '{8'h61, 8'h62, 8'h63, 8'h64};
    check_seq("pp3_seq", base, exp);

    // Reset while in LF after the CR went out
    base = seen.size();
    uart_io_full = 1'b1;
    write_reg(ADR_CTRL, 8'h01);
    write_reg(ADR_DATA, 8'h0A);
    write_reg(ADR_DATA, 8'h41);
    write_reg(ADR_DATA, 8'h42);
    read_reg(ADR_STATUS, rd);
    check("rstlf_status_pre", rd, 32'h0000_0300);
    uart_io_full = 1'b0;
    step();
    check("rstlf_cr_we", 32'(uart_io_we), 32'h1);
    check("rstlf_cr_char", 32'(uart_io_char), 32'h0D);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstlf_we", 32'(uart_io_we), 32'h0);
    check("rstlf_char", 32'(uart_io_char), 32'h0);
    check("rstlf_idle", 32'(tx_idle), 32'h1);
    read_reg(ADR_STATUS, rd);
    check("rstlf_status", rd, 32'h0000_0002);
    read_reg(ADR_CTRL, rd);
    check("rstlf_ctrl", rd, 32'h0);
    repeat (10) step();
    exp = '{8'h0D};
    check_seq("rstlf_seq", base, exp);

    check("strobe_gap", 32'(gap_viol), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
